// File: rtl/uart_tx_fifo_pkg.sv
// rtl/uart_tx_fifo_pkg.sv - shared addresses, FSM encodings and status-word helper for the buffered UART transmitter
package uart_tx_fifo_pkg;

    localparam logic [31:0] UART_ADDR        = 32'h1000_0000;
    localparam logic [31:0] UART_STATUS_ADDR = 32'h1000_0004;

    localparam logic [1:0] UART_ST_IDLE  = 2'd0;
    localparam logic [1:0] UART_ST_START = 2'd1;
    localparam logic [1:0] UART_ST_DATA  = 2'd2;
    localparam logic [1:0] UART_ST_STOP  = 2'd3;

    // Status word returned on reads of UART_STATUS_ADDR.
    function automatic logic [31:0] uart_status_word(input logic full,
                                                     input logic tx_busy,
                                                     input logic overflow);
        return {29'd0, overflow, tx_busy, full};
    endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// rtl/uart_tx_fifo_sync_fifo.sv - register-array synchronous FIFO with registered full/empty/count and combinational head
module sync_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_next;
    logic             push;
    logic             pop;

    // Acceptance uses the registered full, so a same-cycle pop never frees a slot early.
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count_next;
            full  <= (count_next == CNT_FULL);
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered 8N1 UART transmitter with registered full/busy/overflow status
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH        = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     ovf_clr,
    output logic                     tx,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     tx_busy,
    output logic                     overflow
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic [1:0]    state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic          tx_n;
    logic          pop;
    logic          accept;
    logic          baud_done;
    logic [7:0]    head;
    logic [CW-1:0] count_n;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    assign accept    = wr_en && !full;
    assign baud_done = (baud == BAUD_LAST);

    // tx is registered from the next-state decision so the line changes on the same edge as the state.
    always_comb begin
        state_n   = state;
        baud_n    = baud;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        tx_n      = tx;
        pop       = 1'b0;
        case (state)
            UART_ST_IDLE: begin
                tx_n = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = head;
                    state_n = UART_ST_START;
                    baud_n  = '0;
                    tx_n    = 1'b0;
                end
            end
            UART_ST_START: begin
                if (baud_done) begin
                    state_n   = UART_ST_DATA;
                    baud_n    = '0;
                    bit_idx_n = 3'd0;
                    tx_n      = shift[0];
                end else begin
                    baud_n = baud + BAUD_ONE;
                end
            end
            UART_ST_DATA: begin
                if (baud_done) begin
                    baud_n  = '0;
                    shift_n = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_n = UART_ST_STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        tx_n      = shift[1];
                    end
                end else begin
                    baud_n = baud + BAUD_ONE;
                end
            end
            default: begin
                tx_n = 1'b1;
                if (baud_done) begin
                    state_n = UART_ST_IDLE;
                    baud_n  = '0;
                end else begin
                    baud_n = baud + BAUD_ONE;
                end
            end
        endcase
    end

    always_comb begin
        count_n = count;
        case ({accept, pop})
            2'b10:   count_n = count + CNT_ONE;
            2'b01:   count_n = count - CNT_ONE;
            default: count_n = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= UART_ST_IDLE;
            baud     <= '0;
            bit_idx  <= 3'd0;
            shift    <= 8'd0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            tx      <= tx_n;
            tx_busy <= (state_n != UART_ST_IDLE) || (count_n != '0);
            // A dropped write outranks a clear in the same cycle.
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
